// File: rtl/lvds_pkg.sv
// Shared types and default constants for the LVDS receive path.
// The alignment FSM and its lock-loss filter both import this package.
package lvds_pkg;

  // Deserialization factor of the SERDES (bits per parallel word).
  localparam int LVDS_DATA_W = 10;

  // Training word that the transmitter sends while the link is being aligned.
  localparam logic [LVDS_DATA_W-1:0] LVDS_TRAIN_PATTERN = 10'h3E0;

  // States of the word-alignment / link supervisor.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    SLIP   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } align_state_t;

endpackage : lvds_pkg

// File: rtl/lvds_rx_align_ctrl_lock_loss_filter.sv
// Lock-loss glitch filter.
// Counts consecutive cycles in which the lock indication is low while the
// filter is enabled. The loss output pulses for one cycle, on the cycle that
// completes LOSS_FILTER consecutive low samples. The counter then saturates
// so the pulse does not repeat until the lock comes back. A good lock sample
// or a disabled filter clears the count. The block is kept generic so the
// SERDES init controller can reuse it.
module lock_loss_filter #(
  parameter int LOSS_FILTER = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic lock_ok,
  output logic loss
);

  localparam int CW = (LOSS_FILTER < 2) ? 1 : $clog2(LOSS_FILTER + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOSS_FILTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOSS_FILTER - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          loss_s;

  // Next value of the saturating bad-lock counter.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (!en || lock_ok) begin
      cnt_nxt_s = '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Loss fires on the sample that brings the count up to LOSS_FILTER.
  always_comb begin
    loss_s = 1'b0;
    if (en && !lock_ok && (cnt_r == CNT_LAST)) begin
      loss_s = 1'b1;
    end else begin
      loss_s = 1'b0;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign loss = loss_s;

endmodule : lock_loss_filter

// File: rtl/lvds_rx_align_ctrl.sv
// LVDS receiver word-alignment and link supervisor.
// After the SERDES init controller reports done and both PLL and DPA are
// locked, this block steps the SERDES bitslip until the deserialized word
// equals the training pattern for MATCH_COUNT consecutive cycles. Then it
// declares the link up. A sustained lock loss or an exhausted slip budget
// raises reinit_req so the init controller reruns its sequence.
// All outputs are registered from the current state. As a result, each
// output follows the state register by one clock.
module lvds_rx_align_ctrl
  import lvds_pkg::*;
#(
  parameter int                  DATA_W        = LVDS_DATA_W,
  parameter logic [DATA_W-1:0]   TRAIN_PATTERN = LVDS_TRAIN_PATTERN,
  parameter int                  SLIP_WAIT     = 4,
  parameter int                  MATCH_COUNT   = 8,
  parameter int                  LOSS_FILTER   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_done,
  input  logic                          rx_locked,
  input  logic                          rx_dpa_locked,
  input  logic [DATA_W-1:0]             rx_data,
  output logic                          rx_bitslip,
  output logic                          link_up,
  output logic                          reinit_req,
  output logic                          align_err,
  output logic [$clog2(DATA_W+1)-1:0]   slip_count
);

  localparam int SCW = $clog2(DATA_W + 1);
  localparam int WCW = (SLIP_WAIT < 2) ? 1 : $clog2(SLIP_WAIT + 1);
  localparam int MCW = (MATCH_COUNT < 2) ? 1 : $clog2(MATCH_COUNT + 1);

  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(SLIP_WAIT - 1);
  localparam logic [MCW-1:0] MATCH_LAST = MCW'(MATCH_COUNT - 1);
  localparam logic [SCW-1:0] SLIP_MAX   = SCW'(DATA_W);

  align_state_t   state_r;
  align_state_t   state_nxt_s;
  logic [WCW-1:0] wait_r;
  logic [WCW-1:0] wait_nxt_s;
  logic [MCW-1:0] match_r;
  logic [MCW-1:0] match_nxt_s;
  logic [SCW-1:0] slip_cnt_r;
  logic [SCW-1:0] slip_nxt_s;

  logic lock_ok_s;
  logic filter_en_s;
  logic loss_s;
  logic pattern_hit_s;

  assign lock_ok_s     = rx_locked & rx_dpa_locked;
  assign filter_en_s   = (state_r != IDLE);
  assign pattern_hit_s = (rx_data == TRAIN_PATTERN);

  lock_loss_filter #(
    .LOSS_FILTER (LOSS_FILTER)
  ) u_loss_filter (
    .clk     (clk),
    .reset   (reset),
    .en      (filter_en_s),
    .lock_ok (lock_ok_s),
    .loss    (loss_s)
  );

  // Next-state and counter logic. A deassertion of init_done outside FAIL
  // aborts quietly to IDLE. This abort takes priority over a lock loss seen
  // in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_r;
    match_nxt_s = match_r;
    slip_nxt_s  = slip_cnt_r;

    case (state_r)
      IDLE: begin
        slip_nxt_s  = '0;
        wait_nxt_s  = '0;
        match_nxt_s = '0;
        if (init_done && lock_ok_s) begin
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SETTLE: begin
        if (!init_done) begin
          state_nxt_s = IDLE;
        end else if (loss_s) begin
          state_nxt_s = FAIL;
        end else if (wait_r == WAIT_LAST) begin
          state_nxt_s = CHECK;
          match_nxt_s = '0;
        end else begin
          wait_nxt_s = wait_r + WCW'(1);
        end
      end

      CHECK: begin
        if (!init_done) begin
          state_nxt_s = IDLE;
        end else if (loss_s) begin
          state_nxt_s = FAIL;
        end else if (pattern_hit_s) begin
          if (match_r == MATCH_LAST) begin
            state_nxt_s = LOCKED;
          end else begin
            match_nxt_s = match_r + MCW'(1);
          end
        end else begin
          match_nxt_s = '0;
          if (slip_cnt_r == SLIP_MAX) begin
            state_nxt_s = FAIL;
          end else begin
            state_nxt_s = SLIP;
          end
        end
      end

      SLIP: begin
        if (!init_done) begin
          state_nxt_s = IDLE;
        end else if (loss_s) begin
          state_nxt_s = FAIL;
        end else begin
          state_nxt_s = SETTLE;
          wait_nxt_s  = '0;
          if (slip_cnt_r != SLIP_MAX) begin
            slip_nxt_s = slip_cnt_r + SCW'(1);
          end else begin
            slip_nxt_s = slip_cnt_r;
          end
        end
      end

      LOCKED: begin
        if (!init_done) begin
          state_nxt_s = IDLE;
        end else if (loss_s) begin
          state_nxt_s = FAIL;
        end else begin
          state_nxt_s = LOCKED;
        end
      end

      FAIL: begin
        if (!init_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FAIL;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        wait_nxt_s  = '0;
        match_nxt_s = '0;
        slip_nxt_s  = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      wait_r     <= '0;
      match_r    <= '0;
      slip_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      wait_r     <= wait_nxt_s;
      match_r    <= match_nxt_s;
      slip_cnt_r <= slip_nxt_s;
    end
  end

  // Registered outputs decoded from the current state. align_err is set in
  // FAIL, cleared in LOCKED, and holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_bitslip <= 1'b0;
      link_up    <= 1'b0;
      reinit_req <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      rx_bitslip <= (state_r == SLIP);
      link_up    <= (state_r == LOCKED);
      reinit_req <= (state_r == FAIL);
      if (state_r == FAIL) begin
        align_err <= 1'b1;
      end else if (state_r == LOCKED) begin
        align_err <= 1'b0;
      end else begin
        align_err <= align_err;
      end
    end
  end

  assign slip_count = slip_cnt_r;

endmodule : lvds_rx_align_ctrl

// File: tb/tb_lvds_rx_align_ctrl.sv
// Directed bench for lvds_rx_align_ctrl.
// A small SERDES model rotates rx_data by one bit on every observed bitslip
// pulse. Expected latencies and counts are hand-computed for the default
// parameters: SLIP_WAIT=4, MATCH_COUNT=8, LOSS_FILTER=3, DATA_W=10.
module tb_lvds_rx_align_ctrl;

  localparam logic [9:0] PAT  = 10'h3E0;
  localparam logic [9:0] NOPE = 10'h155;

  logic       clk           = 1'b0;
  logic       reset         = 1'b1;
  logic       init_done     = 1'b0;
  logic       rx_locked     = 1'b0;
  logic       rx_dpa_locked = 1'b0;
  logic [9:0] rx_data       = 10'h000;
  logic       rx_bitslip;
  logic       link_up;
  logic       reinit_req;
  logic       align_err;
  logic [3:0] slip_count;

  int n_cmp      = 0;
  int n_mis      = 0;
  int cyc        = 0;
  int n_pulse    = 0;
  int last_pulse = -1;
  int min_gap    = 1000;
  int t0         = 0;

  always #5 clk = ~clk;

  lvds_rx_align_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .init_done     (init_done),
    .rx_locked     (rx_locked),
    .rx_dpa_locked (rx_dpa_locked),
    .rx_data       (rx_data),
    .rx_bitslip    (rx_bitslip),
    .link_up       (link_up),
    .reinit_req    (reinit_req),
    .align_err     (align_err),
    .slip_count    (slip_count)
  );

  function automatic logic [9:0] rotl1(input logic [9:0] v);
    return {v[8:0], v[9]};
  endfunction

  function automatic logic [9:0] rotr1(input logic [9:0] v);
    return {v[0], v[9:1]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: sample #1 after the rising edge and run the SERDES model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rx_bitslip === 1'b1) begin
      if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
      n_pulse++;
      rx_data = rotl1(rx_data);
    end
  endtask

  task automatic clear_pulses();
    n_pulse    = 0;
    last_pulse = -1;
    min_gap    = 1000;
  endtask

  initial begin
    // 1: reset with random inputs, then idle with init_done low.
    init_done     = 1'($urandom_range(0, 1));
    rx_locked     = 1'($urandom_range(0, 1));
    rx_dpa_locked = 1'($urandom_range(0, 1));
    rx_data       = 10'($urandom_range(0, 1023));
    repeat (3) step();
    check_val("rst_link_up", link_up, 0);
    check_val("rst_reinit", reinit_req, 0);
    check_val("rst_align_err", align_err, 0);
    check_val("rst_bitslip", rx_bitslip, 0);
    check_val("rst_slip_count", slip_count, 0);
    init_done = 1'b0; rx_locked = 1'b1; rx_dpa_locked = 1'b1; rx_data = PAT;
    reset = 1'b0;
    clear_pulses();
    repeat (20) step();
    check_val("idle_pulses", n_pulse, 0);
    check_val("idle_link_up", link_up, 0);

    // 2: already aligned; link_up exactly 13 edges after the enabling edge.
    init_done = 1'b1;
    step();
    repeat (12) step();
    check_val("t2_before_13", link_up, 0);
    step();
    check_val("t2_at_13", link_up, 1);
    check_val("t2_slip_count", slip_count, 0);
    check_val("t2_pulses", n_pulse, 0);
    check_val("t2_align_err", align_err, 0);

    // Abort from LOCKED: link_up drops one cycle after the state leaves.
    init_done = 1'b0;
    step();
    step();
    check_val("abort_link_up", link_up, 0);
    check_val("abort_reinit", reinit_req, 0);

    // 3: three slips required; 1+3*(1+4+1)+4+8 = 31 edges to link_up.
    rx_data = rotr1(rotr1(rotr1(PAT)));
    clear_pulses();
    init_done = 1'b1;
    step();
    t0 = cyc;
    while (link_up !== 1'b1 && (cyc - t0) < 100) step();
    check_val("t3_link_up", link_up, 1);
    check_val("t3_latency", cyc - t0, 31);
    check_val("t3_pulses", n_pulse, 3);
    check_val("t3_min_gap", min_gap, 6);
    check_val("t3_slip_count", slip_count, 3);

    // 4: pattern never found; 10 slips, then FAIL.
    init_done = 1'b0;
    step();
    step();
    rx_data = NOPE;
    clear_pulses();
    init_done = 1'b1;
    step();
    t0 = cyc;
    while (reinit_req !== 1'b1 && (cyc - t0) < 300) step();
    check_val("t4_reinit", reinit_req, 1);
    check_val("t4_pulses", n_pulse, 10);
    check_val("t4_align_err", align_err, 1);
    check_val("t4_link_up", link_up, 0);
    check_val("t4_slip_count", slip_count, 10);
    check_val("t4_min_gap", min_gap, 6);
    init_done = 1'b0;
    step();
    step();
    check_val("t4_reinit_drop", reinit_req, 0);
    check_val("t4_err_sticky", align_err, 1);
    check_val("t4_idle_slip_count", slip_count, 0);

    // 5: lock-loss filtering while LOCKED.
    rx_data = PAT;
    init_done = 1'b1;
    step();
    t0 = cyc;
    while (link_up !== 1'b1 && (cyc - t0) < 50) step();
    check_val("t5_link_up", link_up, 1);
    check_val("t5_err_cleared", align_err, 0);
    rx_dpa_locked = 1'b0;
    step();
    step();
    rx_dpa_locked = 1'b1;
    repeat (4) step();
    check_val("t5_glitch2_link", link_up, 1);
    check_val("t5_glitch2_reinit", reinit_req, 0);
    rx_dpa_locked = 1'b0;
    repeat (3) step();
    rx_dpa_locked = 1'b1;
    step();
    check_val("t5_loss3_link", link_up, 0);
    check_val("t5_loss3_reinit", reinit_req, 1);
    check_val("t5_loss3_err", align_err, 1);
    init_done = 1'b0;
    step();
    step();

    // 6b: init_done dropped mid-CHECK; quiet abort, align_err kept.
    clear_pulses();
    init_done = 1'b1;
    step();
    repeat (6) step();
    init_done = 1'b0;
    step();
    step();
    check_val("t6b_reinit", reinit_req, 0);
    check_val("t6b_link_up", link_up, 0);
    check_val("t6b_align_err", align_err, 1);
    repeat (3) step();
    check_val("t6b_reinit_later", reinit_req, 0);
    check_val("t6b_pulses", n_pulse, 0);

    // 6a: reset pulse mid-SETTLE clears everything, including align_err.
    init_done = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    check_val("t6a_align_err", align_err, 0);
    check_val("t6a_link_up", link_up, 0);
    check_val("t6a_reinit", reinit_req, 0);
    check_val("t6a_slip_count", slip_count, 0);
    init_done = 1'b0;
    #2;
    reset = 1'b0;
    clear_pulses();
    repeat (5) step();
    check_val("t6a_idle_pulses", n_pulse, 0);
    check_val("t6a_idle_err", align_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_lvds_rx_align_ctrl
